// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding, default dimensions and width helpers for the matmul sequencer
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        READ  = 3'd5
    } state_t;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_INNER = 8;
    localparam int DEF_COLS  = 4;

    // Never returns zero so a dimension of 1 or 2 still gets a usable 1-bit index.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// rtl/matmul_seq_ctrl_if.sv - host stream/readout and datapath control signals of the matmul sequencer
interface matmul_seq_ctrl_if
    import matmul_pkg::*;
#(
    parameter int XA_W = addr_w(DEF_ROWS * DEF_INNER),
    parameter int CA_W = addr_w(DEF_INNER * DEF_COLS),
    parameter int RA_W = addr_w(DEF_ROWS * DEF_COLS)
);
    logic            start_in;
    logic            valid_input;
    logic            cs_n;
    logic            x_wr_en;
    logic [XA_W-1:0] x_wr_addr;
    logic            xload_done;
    logic [XA_W-1:0] x_rd_addr;
    logic [CA_W-1:0] coef_addr;
    logic            mac_clr;
    logic            mac_en;
    logic            mac_last;
    logic            web;
    logic [RA_W-1:0] res_addr;
    logic            ry;
    logic            busy;
    logic            finish;

    modport master (
        output start_in, valid_input, cs_n,
        input  x_wr_en, x_wr_addr, xload_done, x_rd_addr, coef_addr,
               mac_clr, mac_en, mac_last, web, res_addr, ry, busy, finish
    );

    modport slave (
        input  start_in, valid_input, cs_n,
        output x_wr_en, x_wr_addr, xload_done, x_rd_addr, coef_addr,
               mac_clr, mac_en, mac_last, web, res_addr, ry, busy, finish
    );

endinterface

// File: rtl/matmul_idx_cnt.sv
// rtl/matmul_idx_cnt.sv - nested i/j/k loop counter with per-level last flags
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int INNER = DEF_INNER,
    parameter int COLS  = DEF_COLS,
    localparam int I_W  = addr_w(ROWS),
    localparam int K_W  = addr_w(INNER),
    localparam int J_W  = addr_w(COLS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           k_en,
    input  logic           ij_en,
    output logic [I_W-1:0] i,
    output logic [J_W-1:0] j,
    output logic [K_W-1:0] k,
    output logic           i_last,
    output logic           j_last,
    output logic           k_last
);

    assign i_last = (i == I_W'(ROWS - 1));
    assign j_last = (j == J_W'(COLS - 1));
    assign k_last = (k == K_W'(INNER - 1));

    // k steps through the MAC length; i/j step once per finished element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (k_en) begin
                k <= k_last ? '0 : k + 1'b1;
            end
            if (ij_en) begin
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - top sequencer: X load, MAC scheduling, result write and host readout
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int INNER = DEF_INNER,
    parameter int COLS  = DEF_COLS,
    parameter int XA_W  = addr_w(ROWS * INNER),
    parameter int CA_W  = addr_w(INNER * COLS),
    parameter int RA_W  = addr_w(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    matmul_seq_ctrl_if.slave bus
);

    localparam int I_W = addr_w(ROWS);
    localparam int K_W = addr_w(INNER);
    localparam int J_W = addr_w(COLS);

    state_t          state;
    state_t          state_nx;
    logic [XA_W-1:0] load_cnt;
    logic [RA_W-1:0] rd_cnt;
    logic [I_W-1:0]  i;
    logic [J_W-1:0]  j;
    logic [K_W-1:0]  k;
    logic            i_last;
    logic            j_last;
    logic            k_last;
    logic            cnt_clr;
    logic            k_en;
    logic            ij_en;
    logic            load_last;
    logic            rd_last;
    logic            accept;
    logic            issue;
    logic            rd_issue;
    logic            all_done;
    logic [RA_W-1:0] res_wr_addr;
    logic            mac_en_q;
    logic            mac_clr_q;
    logic            mac_last_q;
    logic            xload_done_q;
    logic            finish_q;
    logic            ry_q;

    matmul_idx_cnt #(
        .ROWS  (ROWS),
        .INNER (INNER),
        .COLS  (COLS)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (cnt_clr),
        .k_en   (k_en),
        .ij_en  (ij_en),
        .i      (i),
        .j      (j),
        .k      (k),
        .i_last (i_last),
        .j_last (j_last),
        .k_last (k_last)
    );

    assign load_last   = (load_cnt == XA_W'(ROWS * INNER - 1));
    assign rd_last     = (rd_cnt == RA_W'(ROWS * COLS - 1));
    assign accept      = (state == LOAD) && bus.valid_input;
    assign issue       = (state == CALC);
    assign rd_issue    = (state == READ) && !bus.cs_n;
    assign all_done    = (state == WRITE) && i_last && j_last;
    assign res_wr_addr = RA_W'(i * COLS + j);

    assign bus.x_wr_addr  = load_cnt;
    assign bus.x_rd_addr  = XA_W'(i * INNER + k);
    assign bus.coef_addr  = CA_W'(k * COLS + j);
    assign bus.mac_en     = mac_en_q;
    assign bus.mac_clr    = mac_clr_q;
    assign bus.mac_last   = mac_last_q;
    assign bus.xload_done = xload_done_q;
    assign bus.finish     = finish_q;
    assign bus.ry         = ry_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start_in) state_nx = LOAD;
            LOAD:    if (accept && load_last) state_nx = CALC;
            CALC:    if (k_last) state_nx = DRAIN;
            DRAIN:   state_nx = WRITE;
            WRITE:   state_nx = (i_last && j_last) ? READ : CALC;
            READ:    if (rd_issue && rd_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.x_wr_en  = 1'b0;
        bus.web      = 1'b1;
        bus.busy     = 1'b1;
        bus.res_addr = '0;
        cnt_clr      = 1'b0;
        k_en         = 1'b0;
        ij_en        = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                cnt_clr  = 1'b1;
            end
            LOAD:  bus.x_wr_en = bus.valid_input;
            CALC:  k_en = 1'b1;
            WRITE: begin
                bus.web      = 1'b0;
                bus.res_addr = res_wr_addr;
                ij_en        = 1'b1;
            end
            READ:  bus.res_addr = rd_cnt;
            default: ;
        endcase
    end

    // Load and readout counters only move on accepted bytes / issued reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            if (accept) begin
                load_cnt <= load_last ? '0 : load_cnt + 1'b1;
            end
            if (rd_issue) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    // X buffer and coefficient ROM answer one cycle after the address, so the
    // MAC strobes are the issue strobe delayed by one register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_last_q   <= 1'b0;
            xload_done_q <= 1'b0;
            finish_q     <= 1'b0;
            ry_q         <= 1'b0;
        end else begin
            mac_en_q     <= issue;
            mac_clr_q    <= issue && (k == '0);
            mac_last_q   <= issue && k_last;
            xload_done_q <= accept && load_last;
            finish_q     <= all_done;
            ry_q         <= rd_issue;
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - scoreboard bench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if bus ();

    matmul_seq_ctrl dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    int exp_wr[$];
    int exp_mac[$];
    int exp_res[$];
    int exp_rd[$];
    bit mon_on = 1'b0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int n_fin = 0;
    int ry_n = 0;
    int ry_first = 0;
    int ry_last = 0;
    int prev_xa = 0;
    int prev_ca = 0;
    int prev_res = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (mon_on) begin
                if (bus.x_wr_en) begin
                    if (exp_wr.size() == 0) chk("x_wr_unexpected", exp_wr.size(), 1);
                    else chk("x_wr_addr", int'(bus.x_wr_addr), exp_wr.pop_front());
                    last_wr_cyc = cyc;
                end
                if (bus.xload_done) begin
                    n_done++;
                    done_cyc = cyc;
                    chk("xload_done_lat", cyc - last_wr_cyc, 1);
                end
                if (bus.mac_en) begin
                    if (exp_mac.size() == 0) chk("mac_unexpected", exp_mac.size(), 1);
                    else chk("mac_addr_flags",
                             (prev_xa << 8) | (prev_ca << 2) | (int'(bus.mac_clr) << 1) | int'(bus.mac_last),
                             exp_mac.pop_front());
                end
                if (!bus.web) begin
                    if (exp_res.size() == 0) chk("web_unexpected", exp_res.size(), 1);
                    else chk("res_wr_addr", int'(bus.res_addr), exp_res.pop_front());
                end
                if (bus.finish) begin
                    n_fin++;
                    chk("finish_lat", cyc - done_cyc, 160);
                end
                if (bus.ry) begin
                    if (ry_n == 0) ry_first = cyc;
                    ry_last = cyc;
                    ry_n++;
                    if (exp_rd.size() == 0) chk("ry_unexpected", exp_rd.size(), 1);
                    else begin
                        chk("rd_addr", prev_res, exp_rd.pop_front());
                        if (exp_rd.size() == 0) chk("idle_at_last_ry", int'(bus.busy), 0);
                    end
                end
            end
            prev_xa  = int'(bus.x_rd_addr);
            prev_ca  = int'(bus.coef_addr);
            prev_res = int'(bus.res_addr);
        end
    end

    // Called at posedge+1 in IDLE; leaves the bench at posedge+1 of the first CALC cycle.
    task automatic run_load();
        int n = 0;
        int c = 0;
        for (int e = 0; e < 16; e++) begin
            for (int kk = 0; kk < 8; kk++) begin
                exp_mac.push_back((((e / 4) * 8 + kk) << 8) | ((kk * 4 + (e % 4)) << 2) |
                                  (((kk == 0) ? 1 : 0) << 1) | ((kk == 7) ? 1 : 0));
            end
            exp_res.push_back(e);
        end
        bus.start_in = 1'b1;
        bus.valid_input = 1'b1;
        @(posedge clk); #1;
        while (n < 32 && c < 200) begin
            bus.valid_input = (c % 3 != 2);
            bus.start_in = (c % 5 == 1);
            if (bus.valid_input) begin
                exp_wr.push_back(n);
                n++;
            end
            c++;
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
        bus.start_in = 1'b0;
        chk("load_bytes", n, 32);
    endtask

    task automatic wait_finish();
        int t = 0;
        int f0 = n_fin;
        while (n_fin == f0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("finish_seen", n_fin - f0, 1);
        chk("calc_queues_empty", exp_mac.size() + exp_res.size() + exp_wr.size(), 0);
    endtask

    task automatic run_read(input bit toggle, input bit b2b);
        int t = 0;
        ry_n = 0;
        for (int a = 0; a < 16; a++) exp_rd.push_back(a);
        if (b2b) bus.start_in = 1'b1;
        while (t < 300) begin
            @(posedge clk); #1;
            if (!bus.busy) break;
            bus.cs_n = toggle ? (t % 3 != 0) : 1'b0;
            t++;
        end
        bus.cs_n = 1'b1;
        chk("read_to_idle", int'(bus.busy), 0);
        @(negedge clk); #1;
        chk("ry_count", ry_n, 16);
        chk("rd_queue_empty", exp_rd.size(), 0);
        if (!toggle) chk("ry_span", ry_last - ry_first, 15);
    endtask

    initial begin
        int strobes;
        bus.start_in = 1'b0;
        bus.valid_input = 1'b0;
        bus.cs_n = 1'b1;
        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_web", int'(bus.web), 1);
        chk("rst_mac_en", int'(bus.mac_en), 0);
        chk("rst_ry", int'(bus.ry), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // abort in the middle of the first element
        run_load();
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_x_rd_addr", int'(bus.x_rd_addr), 3);
        chk("pre_rst_coef_addr", int'(bus.coef_addr), 12);
        chk("pre_rst_mac_en", int'(bus.mac_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_web", int'(bus.web), 1);
        chk("arst_mac_en", int'(bus.mac_en), 0);
        chk("arst_x_rd_addr", int'(bus.x_rd_addr), 0);
        chk("arst_coef_addr", int'(bus.coef_addr), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_wr.delete();
        exp_mac.delete();
        exp_res.delete();
        mon_on = 1'b1;
        strobes = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.busy || bus.mac_en || !bus.web || bus.ry || bus.finish || bus.x_wr_en) strobes++;
        end
        chk("idle_no_strobes", strobes, 0);

        // run A: gapped load, full calc, hold-low readout, immediate restart
        run_load();
        wait_finish();
        run_read(1'b0, 1'b1);
        // run B: restarted from the first IDLE cycle, toggled readout
        run_load();
        wait_finish();
        run_read(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("xload_done_pulses", n_done, 2);
        chk("finish_pulses", n_fin, 2);
        chk("final_busy", int'(bus.busy), 0);
        chk("final_queues", exp_wr.size() + exp_mac.size() + exp_res.size() + exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
